zn_autotuner: RTL and testbench
===============================

Name: zn_autotuner

Overview:
- Parametrised Ziegler-Nichols autotuner, next generation of the speed-loop gain tuner.
- Ramps a trial proportional gain and watches the measured speed period for sustained oscillation, giving ultimate gain Ku and oscillation period Tu in samples.
- Computes Kp/Ki/Kd for P, PI or PID with a shared multi-cycle divider.
- Adds start/busy handshake, sample-valid qualification, peak tolerance, gain saturation, fractional Ki and a fail state.

Parameters:
- DATA_WIDTH, 16, width of period_speed samples and Tu counter.
- GAIN_WIDTH, 8, width of Kp/Ki/Kd/kp_trial outputs.
- KP_LIMIT, 255, largest trial gain before tuning fails.
- PEAK_TOL, 0, absolute difference between consecutive peak levels treated as "equal".
- KI_FRAC, 8, Ki output is scaled by 2^KI_FRAC (fixed-point fraction bits).
- TIMEOUT_SAMPLES, 4096, watchdog limit (only with optional feature).

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; begins tuning from IDLE/DONE/FAIL
- pid_select  in  3  100=P, 110=PI, 111=PID, other=zero gains
- sample_valid  in  1  qualifies period_speed; peak logic advances only when high
- period_speed  in  DATA_WIDTH  measured speed (period in clock cycles)
- kp_trial  out  GAIN_WIDTH  gain currently applied to the plant during search
- busy  out  1  high in any state except IDLE/DONE/FAIL
- tuning_done  out  1  high in DONE
- tuning_fail  out  1  high in FAIL
- Kp, Ki, Kd  out  GAIN_WIDTH each  tuned gains

Behaviour:
Reset values:
- All outputs 0, state IDLE, kp_trial 0.
- Reset mid-operation aborts immediately, including any divider run.

States: IDLE, SEARCH, CALC_KP, CALC_KI, CALC_KD, DONE, FAIL.
- start in IDLE/DONE/FAIL -> SEARCH with kp_trial=1; peak history, Tu counter and outputs cleared.
- start while busy is ignored.

SEARCH (per valid sample only):
- Rising flag sets when sample > previous sample.
- Peak = rising flag set and sample < previous. Peak level is the previous sample; Tu = samples since last peak; counter saturates at all-ones.
- First peak is only recorded.
- Each later peak compares against the prior peak:
  - |diff| <= PEAK_TOL -> lock Ku=kp_trial -> CALC_KP.
  - Lower -> kp_trial+1.
  - Higher -> kp_trial-1, floored at 1.
- kp_trial+1 > KP_LIMIT -> FAIL.

CALC states:
- Each CALC state issues one divider job; the state is held until div_done.
- All products are formed at 2*DATA_WIDTH, truncating division.
- Results saturate to 2^GAIN_WIDTH-1.
- P: Kp = Ku>>1, no divide; Ki=Kd=0; go directly to DONE (one cycle).
- PI: Kp = 45*Ku/100; Ki = (54*Ku<<KI_FRAC)/(100*Tu); Kd=0.
- PID: Kp = 6*Ku/10; Ki = (12*Ku<<KI_FRAC)/(10*Tu); Kd = 3*Ku*Tu/40.
- Tu=0 gives Ki = max.
- Invalid pid_select: gains 0, DONE.
- pid_select is sampled on entry to CALC_KP.

DONE and FAIL:
- DONE holds gains until the next start.
- FAIL forces Kp=Ki=Kd=0.
- Divider latency: 2*DATA_WIDTH+2 cycles from div_start to div_done.

Optional Feature:
- Macro AUTOTUNE_TIMEOUT_EN.
- Defined: SEARCH counts valid samples since entry; reaching TIMEOUT_SAMPLES -> FAIL.
- Undefined: no watchdog; SEARCH may run indefinitely.

Decomposition:
- Package zn_autotuner_pkg holds:
  - state enum encoding;
  - pid_select codes (SEL_P, SEL_PI, SEL_PID);
  - Z-N rule constants (45/100, 54/100, 6/10, 12/10, 3/40).
- One sub-module, seq_divider:
  - parametrised width, restoring radix-2;
  - start/done handshake, done is one-cycle;
  - divide-by-zero returns all-ones quotient;
  - own async reset on reset.

Test Plan:
- Reset mid-SEARCH at kp_trial=7 -> all outputs 0, busy 0, IDLE; next start restarts at kp_trial=1.
- Plant model with peak = 1000-10*(20-kp_trial) below Ku=20, constant above, Tu=40; pid_select=111 -> Kp=12, Ki=153, Kd=60, tuning_done=1.
- Same plant, pid_select=110 -> Kp=9, Ki=69, Kd=0; pid_select=100 -> Kp=10, Ki=Kd=0.
- Ever-decaying peaks with KP_LIMIT=5 -> FAIL after kp_trial reaches 5 and a sixth lower peak; gains 0, tuning_fail=1.
- Peaks 800/802 with PEAK_TOL=2 -> lock on that pair; sample_valid low for 10 cycles between samples -> Tu unchanged.
- With AUTOTUNE_TIMEOUT_EN and TIMEOUT_SAMPLES=64, flat input -> FAIL on the 64th valid sample; without the macro, still in SEARCH.

Source files
------------

// File: rtl/zn_autotuner_pkg.sv
// Shared types and Ziegler-Nichols rule constants for the autotuner.
package zn_autotuner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_CALC_KP,
    ST_CALC_KI,
    ST_CALC_KD,
    ST_DONE,
    ST_FAIL
  } state_e;

  localparam logic [2:0] SEL_P   = 3'b100;
  localparam logic [2:0] SEL_PI  = 3'b110;
  localparam logic [2:0] SEL_PID = 3'b111;

  localparam int PI_KP_NUM  = 45;
  localparam int PI_KP_DEN  = 100;
  localparam int PI_KI_NUM  = 54;
  localparam int PI_KI_DEN  = 100;
  localparam int PID_KP_NUM = 6;
  localparam int PID_KP_DEN = 10;
  localparam int PID_KI_NUM = 12;
  localparam int PID_KI_DEN = 10;
  localparam int PID_KD_NUM = 3;
  localparam int PID_KD_DEN = 40;

endpackage

// File: rtl/zn_autotuner_seq_divider.sv
// Restoring radix-2 unsigned divider, WIDTH+2 cycles from start_i to the one-cycle done_o.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o
);

  localparam int CW = $clog2(WIDTH + 2);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic [WIDTH:0]   trial, diff;

  // A zero divisor never borrows, so every quotient bit becomes 1.
  assign trial = {rem_q, quo_q[WIDTH-1]};
  assign diff  = trial - {1'b0, dvs_q};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q <= '0;
        quo_q <= dividend_i;
        dvs_q <= divisor_i;
        cnt_q <= CW'(WIDTH + 1);
      end else if (cnt_q > CW'(1)) begin
        if (!diff[WIDTH]) begin
          rem_q <= diff[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_q <= trial[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_q <= cnt_q - 1'b1;
      end else if (cnt_q == CW'(1)) begin
        done_q <= 1'b1;
        cnt_q  <= '0;
      end
    end
  end

  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/zn_autotuner.sv
// Ziegler-Nichols autotuner: gain ramp search for Ku/Tu, then P/PI/PID gain calculation.
// Optional search watchdog enabled by defining AUTOTUNE_TIMEOUT_EN.
module zn_autotuner
  import zn_autotuner_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int GAIN_WIDTH      = 8,
  parameter int KP_LIMIT        = 255,
  parameter int PEAK_TOL        = 0,
  parameter int KI_FRAC         = 8,
  parameter int TIMEOUT_SAMPLES = 4096
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [2:0]            pid_select_i,
  input  logic                  sample_valid_i,
  input  logic [DATA_WIDTH-1:0] period_speed_i,
  output logic [GAIN_WIDTH-1:0] kp_trial_o,
  output logic                  busy_o,
  output logic                  tuning_done_o,
  output logic                  tuning_fail_o,
  output logic [GAIN_WIDTH-1:0] kp_o,
  output logic [GAIN_WIDTH-1:0] ki_o,
  output logic [GAIN_WIDTH-1:0] kd_o
);

  localparam int W = 2 * DATA_WIDTH;
  localparam logic [GAIN_WIDTH:0]   KP_LIM = (GAIN_WIDTH+1)'(KP_LIMIT);
  localparam logic [DATA_WIDTH-1:0] TOL    = DATA_WIDTH'(PEAK_TOL);

  state_e                state_q;
  logic [GAIN_WIDTH-1:0] kp_trial_q, ku_q, kp_q, ki_q, kd_q;
  logic [DATA_WIDTH-1:0] prev_q, pk_lvl_q, cnt_q, tu_q;
  logic                  prev_vld_q, rising_q, pk_vld_q, job_q, div_start_q;
  logic [2:0]            sel_q;
  logic [W-1:0]          num_q, den_q, num_d, den_d, ku_w, tu_w, quot;
  logic                  div_done, busy, peak, is_pid, is_pi;
  logic [DATA_WIDTH-1:0] tu_now, absdiff;
  logic [GAIN_WIDTH:0]   kp_inc;
`ifdef AUTOTUNE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_SAMPLES + 1);
  logic [WD_W-1:0] wd_q;
`endif

  function automatic logic [GAIN_WIDTH-1:0] sat(input logic [W-1:0] v);
    return (|(v >> GAIN_WIDTH)) ? '1 : v[GAIN_WIDTH-1:0];
  endfunction

  assign busy    = !(state_q inside {ST_IDLE, ST_DONE, ST_FAIL});
  assign is_pid  = (sel_q == SEL_PID);
  assign is_pi   = (sel_q == SEL_PI);
  assign peak    = rising_q && (period_speed_i < prev_q);
  assign tu_now  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign absdiff = (prev_q >= pk_lvl_q) ? prev_q - pk_lvl_q : pk_lvl_q - prev_q;
  assign kp_inc  = {1'b0, kp_trial_q} + 1'b1;
  assign ku_w    = W'(ku_q);
  assign tu_w    = W'(tu_q);

  // Divider operands for the job owned by the current CALC state.
  always_comb begin
    num_d = '0;
    den_d = '0;
    case (state_q)
      ST_CALC_KP: begin
        num_d = ku_w * W'(is_pid ? PID_KP_NUM : PI_KP_NUM);
        den_d = W'(is_pid ? PID_KP_DEN : PI_KP_DEN);
      end
      ST_CALC_KI: begin
        num_d = (ku_w * W'(is_pid ? PID_KI_NUM : PI_KI_NUM)) << KI_FRAC;
        den_d = tu_w * W'(is_pid ? PID_KI_DEN : PI_KI_DEN);
      end
      ST_CALC_KD: begin
        num_d = ku_w * tu_w * W'(PID_KD_NUM);
        den_d = W'(PID_KD_DEN);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      kp_trial_q  <= '0;
      ku_q        <= '0;
      kp_q        <= '0;
      ki_q        <= '0;
      kd_q        <= '0;
      prev_q      <= '0;
      pk_lvl_q    <= '0;
      cnt_q       <= '0;
      tu_q        <= '0;
      prev_vld_q  <= 1'b0;
      rising_q    <= 1'b0;
      pk_vld_q    <= 1'b0;
      job_q       <= 1'b0;
      div_start_q <= 1'b0;
      sel_q       <= '0;
      num_q       <= '0;
      den_q       <= '0;
`ifdef AUTOTUNE_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      div_start_q <= 1'b0;
      if (start_i && !busy) begin
        state_q    <= ST_SEARCH;
        kp_trial_q <= GAIN_WIDTH'(1);
        kp_q       <= '0;
        ki_q       <= '0;
        kd_q       <= '0;
        prev_vld_q <= 1'b0;
        rising_q   <= 1'b0;
        pk_vld_q   <= 1'b0;
        cnt_q      <= '0;
        job_q      <= 1'b0;
`ifdef AUTOTUNE_TIMEOUT_EN
        wd_q       <= '0;
`endif
      end else begin
        case (state_q)
          ST_SEARCH: if (sample_valid_i) begin
            prev_q     <= period_speed_i;
            prev_vld_q <= 1'b1;
            rising_q   <= peak ? 1'b0 : (rising_q | (prev_vld_q && period_speed_i > prev_q));
            cnt_q      <= peak ? '0 : tu_now;
`ifdef AUTOTUNE_TIMEOUT_EN
            wd_q <= wd_q + 1'b1;
            if (wd_q == WD_W'(TIMEOUT_SAMPLES - 1)) state_q <= ST_FAIL;
`endif
            if (peak) begin
              pk_vld_q <= 1'b1;
              pk_lvl_q <= prev_q;
              if (pk_vld_q) begin
                if (absdiff <= TOL) begin
                  ku_q    <= kp_trial_q;
                  tu_q    <= tu_now;
                  sel_q   <= pid_select_i;
                  state_q <= ST_CALC_KP;
                end else if (prev_q < pk_lvl_q) begin
                  if (kp_inc > KP_LIM) state_q <= ST_FAIL;
                  else                 kp_trial_q <= kp_inc[GAIN_WIDTH-1:0];
                end else if (kp_trial_q > GAIN_WIDTH'(1)) begin
                  kp_trial_q <= kp_trial_q - 1'b1;
                end
              end
            end
          end
          ST_CALC_KP, ST_CALC_KI, ST_CALC_KD: begin
            if (!job_q) begin
              if (state_q == ST_CALC_KP && sel_q == SEL_P) begin
                kp_q    <= ku_q >> 1;
                state_q <= ST_DONE;
              end else if (state_q == ST_CALC_KP && !is_pi && !is_pid) begin
                state_q <= ST_DONE;
              end else begin
                job_q       <= 1'b1;
                div_start_q <= 1'b1;
                num_q       <= num_d;
                den_q       <= den_d;
              end
            end else if (div_done) begin
              job_q <= 1'b0;
              if (state_q == ST_CALC_KP) begin
                kp_q    <= sat(quot);
                state_q <= ST_CALC_KI;
              end else if (state_q == ST_CALC_KI) begin
                ki_q    <= sat(quot);
                state_q <= is_pid ? ST_CALC_KD : ST_DONE;
              end else begin
                kd_q    <= sat(quot);
                state_q <= ST_DONE;
              end
            end
          end
          ST_FAIL: begin
            kp_q <= '0;
            ki_q <= '0;
            kd_q <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  seq_divider #(.WIDTH(W)) u_div (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .start_i    (div_start_q),
    .dividend_i (num_q),
    .divisor_i  (den_q),
    .done_o     (div_done),
    .quotient_o (quot)
  );

  assign kp_trial_o    = kp_trial_q;
  assign busy_o        = busy;
  assign tuning_done_o = (state_q == ST_DONE);
  assign tuning_fail_o = (state_q == ST_FAIL);
  assign kp_o          = kp_q;
  assign ki_o          = ki_q;
  assign kd_o          = kd_q;

endmodule

// File: tb/tb_zn_autotuner.sv
// Directed bench for zn_autotuner: three instances (default, KP_LIMIT=5, PEAK_TOL=2/TIMEOUT=64).
module tb_zn_autotuner;
  localparam int DW = 16;
  localparam int GW = 8;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, sample_valid = 1'b0;
  logic [2:0]    pid_select = 3'b111;
  logic [DW-1:0] period_speed = '0;
  logic [GW-1:0] d_kpt, d_kp, d_ki, d_kd, l_kpt, l_kp, l_ki, l_kd, t_kpt, t_kp, t_ki, t_kd;
  logic          d_busy, d_done, d_fail, l_busy, l_done, l_fail, t_busy, t_done, t_fail;
  int            checks = 0, errors = 0;

  always #10 clk = ~clk;

  zn_autotuner u_dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .pid_select_i(pid_select),
    .sample_valid_i(sample_valid), .period_speed_i(period_speed), .kp_trial_o(d_kpt),
    .busy_o(d_busy), .tuning_done_o(d_done), .tuning_fail_o(d_fail),
    .kp_o(d_kp), .ki_o(d_ki), .kd_o(d_kd));

  zn_autotuner #(.KP_LIMIT(5)) u_lim (
    .clk_i(clk), .reset_i(reset), .start_i(start), .pid_select_i(pid_select),
    .sample_valid_i(sample_valid), .period_speed_i(period_speed), .kp_trial_o(l_kpt),
    .busy_o(l_busy), .tuning_done_o(l_done), .tuning_fail_o(l_fail),
    .kp_o(l_kp), .ki_o(l_ki), .kd_o(l_kd));

  zn_autotuner #(.PEAK_TOL(2), .TIMEOUT_SAMPLES(64)) u_tol (
    .clk_i(clk), .reset_i(reset), .start_i(start), .pid_select_i(pid_select),
    .sample_valid_i(sample_valid), .period_speed_i(period_speed), .kp_trial_o(t_kpt),
    .busy_o(t_busy), .tuning_done_o(t_done), .tuning_fail_o(t_fail),
    .kp_o(t_kp), .ki_o(t_ki), .kd_o(t_kd));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; sample_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sample(input int v, input int gap);
    sample_valid = 1'b1; period_speed = DW'(v);
    tick();
    sample_valid = 1'b0; period_speed = '1;
    repeat (gap) tick();
  endtask

  // One 40-sample triangle whose top is amp; the peak is seen on sample 21.
  task automatic run_period(input int amp, input int gap);
    for (int i = 0; i < 40; i++) sample(amp - 10 * ((i > 20) ? (i - 20) : (20 - i)), gap);
  endtask

  // Plant decays while kp_trial < 20 and sustains from 20 on (Ku=20, Tu=40).
  task automatic run_plant(input int chk_start);
    int amp;
    amp = 1000;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0 && d_kpt < 8'd20) amp = amp - 10;
      run_period(amp, 0);
      if (chk_start != 0 && k == 5) begin
        pulse_start();
        checks++; if (d_kpt !== 8'd6) begin errors++; $display("FAIL start_while_busy: kp_trial %0d expected 6", d_kpt); end
      end
    end
    for (int i = 0; i < 500 && !d_done; i++) tick();
  endtask

  task automatic test_reset();
    tick();
    checks++; if (d_kpt !== 8'd0) begin errors++; $display("FAIL reset_kp_trial: got %0d expected 0", d_kpt); end
    checks++; if ({d_busy, d_done, d_fail} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {d_busy, d_done, d_fail}); end
    checks++; if ({d_kp, d_ki, d_kd} !== 24'd0) begin errors++; $display("FAIL reset_gains: got %h expected 0", {d_kp, d_ki, d_kd}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_pid();
    do_reset();
    pid_select = 3'b111;
    pulse_start();
    checks++; if (d_kpt !== 8'd1 || d_busy !== 1'b1) begin errors++; $display("FAIL pid_start: kp_trial %0d busy %b expected 1 1", d_kpt, d_busy); end
    run_plant(1);
    checks++; if (d_done !== 1'b1 || d_busy !== 1'b0) begin errors++; $display("FAIL pid_done: done %b busy %b expected 1 0", d_done, d_busy); end
    checks++; if (d_kp !== 8'd12) begin errors++; $display("FAIL pid_kp: got %0d expected 12", d_kp); end
    checks++; if (d_ki !== 8'd153) begin errors++; $display("FAIL pid_ki: got %0d expected 153", d_ki); end
    checks++; if (d_kd !== 8'd60) begin errors++; $display("FAIL pid_kd: got %0d expected 60", d_kd); end
  endtask

  task automatic test_pi();
    pid_select = 3'b110;
    pulse_start();
    checks++; if (d_kp !== 8'd0 || d_kpt !== 8'd1) begin errors++; $display("FAIL restart_clear: kp %0d kp_trial %0d expected 0 1", d_kp, d_kpt); end
    run_plant(0);
    checks++; if (d_done !== 1'b1) begin errors++; $display("FAIL pi_done: got %b expected 1", d_done); end
    checks++; if (d_kp !== 8'd9) begin errors++; $display("FAIL pi_kp: got %0d expected 9", d_kp); end
    checks++; if (d_ki !== 8'd69) begin errors++; $display("FAIL pi_ki: got %0d expected 69", d_ki); end
    checks++; if (d_kd !== 8'd0) begin errors++; $display("FAIL pi_kd: got %0d expected 0", d_kd); end
  endtask

  task automatic test_p();
    pid_select = 3'b100;
    pulse_start();
    run_plant(0);
    checks++; if (d_done !== 1'b1) begin errors++; $display("FAIL p_done: got %b expected 1", d_done); end
    checks++; if ({d_kp, d_ki, d_kd} !== {8'd10, 8'd0, 8'd0}) begin errors++; $display("FAIL p_gains: got %0d/%0d/%0d expected 10/0/0", d_kp, d_ki, d_kd); end
  endtask

  task automatic test_invalid_select();
    pid_select = 3'b010;
    pulse_start();
    run_plant(0);
    checks++; if (d_done !== 1'b1) begin errors++; $display("FAIL inv_done: got %b expected 1", d_done); end
    checks++; if ({d_kp, d_ki, d_kd} !== 24'd0) begin errors++; $display("FAIL inv_gains: got %0d/%0d/%0d expected 0/0/0", d_kp, d_ki, d_kd); end
  endtask

  task automatic test_reset_mid_search();
    int amp;
    do_reset();
    pid_select = 3'b111;
    pulse_start();
    amp = 1000;
    for (int k = 0; k < 20 && d_kpt != 8'd7; k++) begin
      run_period(amp, 0);
      amp = amp - 10;
    end
    checks++; if (d_kpt !== 8'd7) begin errors++; $display("FAIL mid_reach7: kp_trial %0d expected 7", d_kpt); end
    reset = 1'b1;
    #3;
    checks++; if ({d_kpt, d_kp, d_ki, d_kd} !== 32'd0) begin errors++; $display("FAIL mid_reset_vals: got %h expected 0", {d_kpt, d_kp, d_ki, d_kd}); end
    checks++; if ({d_busy, d_done, d_fail} !== 3'b000) begin errors++; $display("FAIL mid_reset_flags: got %b expected 000", {d_busy, d_done, d_fail}); end
    tick();
    reset = 1'b0;
    tick();
    pulse_start();
    checks++; if (d_kpt !== 8'd1 || d_busy !== 1'b1) begin errors++; $display("FAIL mid_restart: kp_trial %0d busy %b expected 1 1", d_kpt, d_busy); end
  endtask

  task automatic test_kp_limit();
    do_reset();
    pulse_start();
    for (int k = 0; k < 5; k++) run_period(1000 - 10 * k, 0);
    checks++; if (l_kpt !== 8'd5 || l_busy !== 1'b1) begin errors++; $display("FAIL lim_at5: kp_trial %0d busy %b expected 5 1", l_kpt, l_busy); end
    run_period(950, 0);
    checks++; if (l_fail !== 1'b1 || l_busy !== 1'b0 || l_done !== 1'b0) begin errors++; $display("FAIL lim_fail: fail %b busy %b done %b expected 1 0 0", l_fail, l_busy, l_done); end
    checks++; if ({l_kp, l_ki, l_kd} !== 24'd0) begin errors++; $display("FAIL lim_gains: got %h expected 0", {l_kp, l_ki, l_kd}); end
    checks++; if (d_busy !== 1'b1 || d_kpt !== 8'd6) begin errors++; $display("FAIL lim_default: busy %b kp_trial %0d expected 1 6", d_busy, d_kpt); end
  endtask

  task automatic test_peak_tol();
    do_reset();
    pid_select = 3'b111;
    pulse_start();
    run_period(800, 10);
    run_period(802, 10);
    for (int i = 0; i < 500 && !t_done; i++) tick();
    checks++; if (t_done !== 1'b1) begin errors++; $display("FAIL tol_done: got %b expected 1", t_done); end
    checks++; if ({t_kp, t_ki, t_kd} !== {8'd0, 8'd7, 8'd3}) begin errors++; $display("FAIL tol_gains: got %0d/%0d/%0d expected 0/7/3", t_kp, t_ki, t_kd); end
    checks++; if (d_busy !== 1'b1 || d_kpt !== 8'd1) begin errors++; $display("FAIL tol_zero_floor: busy %b kp_trial %0d expected 1 1", d_busy, d_kpt); end
  endtask

  task automatic test_timeout();
    do_reset();
    pulse_start();
    repeat (63) sample(500, 0);
    checks++; if (t_busy !== 1'b1 || t_fail !== 1'b0) begin errors++; $display("FAIL wd_before: busy %b fail %b expected 1 0", t_busy, t_fail); end
    sample(500, 0);
`ifdef AUTOTUNE_TIMEOUT_EN
    checks++; if (t_fail !== 1'b1 || t_busy !== 1'b0) begin errors++; $display("FAIL wd_fire: fail %b busy %b expected 1 0", t_fail, t_busy); end
`else
    checks++; if (t_busy !== 1'b1 || t_fail !== 1'b0) begin errors++; $display("FAIL wd_absent: busy %b fail %b expected 1 0", t_busy, t_fail); end
`endif
  endtask

  initial begin
    test_reset();
    test_pid();
    test_pi();
    test_p();
    test_invalid_select();
    test_reset_mid_search();
    test_kp_limit();
    test_peak_tol();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
